// File: rtl/forward_hazard_unit.sv
// EXE-stage operand forwarding with x0 exclusion and a one-cycle load-use stall.
// Define FWD_STATS_EN to add the fwd_cnt/stall_cnt event counters.
module forward_hazard_unit #(
    parameter int XLEN   = 32,
    parameter int RBITS  = 5,
    parameter int NPORTS = 2
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic                    id_valid,
    input  logic [NPORTS*RBITS-1:0] rs,
    input  logic [NPORTS*XLEN-1:0]  ReadData,
    input  logic                    preMwk,
    input  logic                    preRegWr,
    input  logic [1:0]              preRegDst,
    input  logic [RBITS-1:0]        prerd,
    input  logic [1:0]              precmp,
    input  logic [XLEN-1:0]         preAluOutput,
    input  logic [XLEN-1:0]         prePC4,
    input  logic                    ppreMwk,
    input  logic                    ppreRegWr,
    input  logic [1:0]              ppreRegDst,
    input  logic [RBITS-1:0]        pprerd,
    input  logic [1:0]              pprecmp,
    input  logic [XLEN-1:0]         ppreAluOutput,
    input  logic [XLEN-1:0]         ppreDataOut,
    input  logic [XLEN-1:0]         pprePC4,
    output logic [NPORTS*XLEN-1:0]  RD,
    output logic                    out_valid,
    output logic                    Stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]             fwd_cnt,
    output logic [31:0]             stall_cnt
`endif
);

    typedef enum logic {ST_RUN, ST_WAIT} state_e;

    state_e                 state_q, state_d;
    logic [NPORTS*XLEN-1:0] rd_q, rd_d;
    logic                   out_valid_q, out_valid_d;
    logic                   stall_q, stall_d;

    logic [NPORTS*XLEN-1:0] fwd;
    logic [XLEN-1:0]        mem_val, wb_val;
    logic [RBITS-1:0]       rs_i;
    logic                   mem_hit, wb_hit;
    logic                   any_fwd, load_hz;
    logic                   unused_cmp_hi;

    assign unused_cmp_hi = precmp[1] ^ pprecmp[1];

    function automatic logic [XLEN-1:0] stage_val(
        input logic [1:0]      dst,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] data,
        input logic [XLEN-1:0] pc4,
        input logic            cmp0
    );
        logic [XLEN-1:0] v;
        case (dst)
            2'b01:   v = data;
            2'b10:   v = pc4;
            2'b11:   v = {{(XLEN-1){1'b0}}, cmp0};
            default: v = alu;
        endcase
        return v;
    endfunction

    // Load data is not available in MEM; a MEM load match always stalls when valid.
    assign mem_val = stage_val(preRegDst, preAluOutput, preAluOutput,
                               prePC4, precmp[0]);
    assign wb_val  = stage_val(ppreRegDst, ppreAluOutput, ppreDataOut,
                               pprePC4, pprecmp[0]);

    always_comb begin
        fwd     = ReadData;
        any_fwd = 1'b0;
        load_hz = 1'b0;
        mem_hit = 1'b0;
        wb_hit  = 1'b0;
        rs_i    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            rs_i    = rs[i*RBITS +: RBITS];
            mem_hit = preMwk && preRegWr && (prerd == rs_i) && (rs_i != '0);
            wb_hit  = ppreMwk && ppreRegWr && (pprerd == rs_i) && (rs_i != '0);
            if (mem_hit) begin
                fwd[i*XLEN +: XLEN] = mem_val;
            end else if (wb_hit) begin
                fwd[i*XLEN +: XLEN] = wb_val;
            end
            any_fwd = any_fwd | mem_hit | wb_hit;
            load_hz = load_hz | (id_valid && mem_hit && (preRegDst == 2'b01));
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        stall_d     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_hz) begin
                    out_valid_d = 1'b0;
                    stall_d     = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    rd_d        = fwd;
                    out_valid_d = id_valid;
                end
            end
            default: begin
                rd_d        = fwd;
                out_valid_d = id_valid;
                state_d     = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_RUN;
            rd_q        <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    assign RD        = rd_q;
    assign out_valid = out_valid_q;
    assign Stall     = stall_q;

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_RUN && load_hz) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else if (id_valid && any_fwd) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_cnt   = fwd_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: vector table, stall/reset sequences,
// and randomized traffic against a rule-level reference model.
module tb_forward_hazard_unit;

    localparam int XLEN = 32;
    localparam int RB   = 5;
    localparam int NP   = 2;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    logic              id_valid;
    logic [NP*RB-1:0]  rs;
    logic [NP*XLEN-1:0] ReadData;
    logic              preMwk, preRegWr;
    logic [1:0]        preRegDst, precmp;
    logic [RB-1:0]     prerd;
    logic [XLEN-1:0]   preAluOutput, prePC4;
    logic              ppreMwk, ppreRegWr;
    logic [1:0]        ppreRegDst, pprecmp;
    logic [RB-1:0]     pprerd;
    logic [XLEN-1:0]   ppreAluOutput, ppreDataOut, pprePC4;
    logic [NP*XLEN-1:0] RD;
    logic              out_valid, Stall;
`ifdef FWD_STATS_EN
    logic [31:0]       fwd_cnt, stall_cnt;
`endif

    forward_hazard_unit #(.XLEN(XLEN), .RBITS(RB), .NPORTS(NP)) dut (
        .CLK(CLK), .Reset(Reset), .id_valid(id_valid), .rs(rs),
        .ReadData(ReadData),
        .preMwk(preMwk), .preRegWr(preRegWr), .preRegDst(preRegDst),
        .prerd(prerd), .precmp(precmp), .preAluOutput(preAluOutput),
        .prePC4(prePC4),
        .ppreMwk(ppreMwk), .ppreRegWr(ppreRegWr), .ppreRegDst(ppreRegDst),
        .pprerd(pprerd), .pprecmp(pprecmp), .ppreAluOutput(ppreAluOutput),
        .ppreDataOut(ppreDataOut), .pprePC4(pprePC4),
        .RD(RD), .out_valid(out_valid), .Stall(Stall)
`ifdef FWD_STATS_EN
        , .fwd_cnt(fwd_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic        v;
        logic [4:0]  r0, r1;
        logic [31:0] d0, d1;
        logic        pm, pw;
        logic [1:0]  pdst, pcmp;
        logic [4:0]  prd;
        logic [31:0] palu, ppc;
        logic        qm, qw;
        logic [1:0]  qdst, qcmp;
        logic [4:0]  qrd;
        logic [31:0] qalu, qdat, qpc;
        logic [31:0] e0, e1;
        logic        ev;
    } vec_t;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] m_rd [NP];
    logic        m_vld, m_wait, m_dc;
    int unsigned m_fwd, m_stl;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t base();
        vec_t t;
        t.v = 1; t.r0 = 1; t.r1 = 2;
        t.d0 = 32'hAAAA_0001; t.d1 = 32'hBBBB_0002;
        t.pm = 0; t.pw = 1; t.pdst = 0; t.pcmp = 0; t.prd = 1;
        t.palu = 32'h5555; t.ppc = 32'h6666;
        t.qm = 0; t.qw = 1; t.qdst = 0; t.qcmp = 0; t.qrd = 2;
        t.qalu = 32'h7777; t.qdat = 32'h8888; t.qpc = 32'h9999;
        t.e0 = t.d0; t.e1 = t.d1; t.ev = 1;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        id_valid = t.v; rs = {t.r1, t.r0}; ReadData = {t.d1, t.d0};
        preMwk = t.pm; preRegWr = t.pw; preRegDst = t.pdst;
        prerd = t.prd; precmp = t.pcmp;
        preAluOutput = t.palu; prePC4 = t.ppc;
        ppreMwk = t.qm; ppreRegWr = t.qw; ppreRegDst = t.qdst;
        pprerd = t.qrd; pprecmp = t.qcmp;
        ppreAluOutput = t.qalu; ppreDataOut = t.qdat; pprePC4 = t.qpc;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] dst,
        input logic [31:0] alu, input logic [31:0] dat,
        input logic [31:0] pc, input logic [1:0] cmp);
        case (dst)
            2'b00:   return alu;
            2'b01:   return dat;
            2'b10:   return pc;
            default: return {31'b0, cmp[0]};
        endcase
    endfunction

    // One clock edge of the reference behaviour, from the current inputs.
    task automatic model_edge();
        logic [4:0]  r;
        logic        mh, wh, hz, anyf, dc;
        logic [31:0] nv [NP];
        hz = 0; anyf = 0; dc = 0;
        for (int p = 0; p < NP; p++) begin
            r  = rs[p*RB +: RB];
            mh = preMwk && preRegWr && prerd == r && r != 0;
            wh = ppreMwk && ppreRegWr && pprerd == r && r != 0;
            nv[p] = ReadData[p*XLEN +: XLEN];
            if (mh) begin
                nv[p] = pick(preRegDst, preAluOutput, 32'h0, prePC4, precmp);
                if (preRegDst == 2'b01) begin
                    dc = 1;
                    hz = hz | id_valid;
                end
            end else if (wh) begin
                nv[p] = pick(ppreRegDst, ppreAluOutput, ppreDataOut,
                             pprePC4, pprecmp);
            end
            anyf = anyf | mh | wh;
        end
        if (!m_wait && hz) begin
            m_wait = 1; m_vld = 0; m_stl++;
        end else begin
            m_wait = 0; m_rd = nv; m_vld = id_valid; m_dc = dc;
            if (id_valid && anyf) m_fwd++;
        end
    endtask

    task automatic rand_pre();
        preMwk = ($urandom_range(0, 3) != 0);
        preRegWr = ($urandom_range(0, 3) != 0);
        preRegDst = 2'($urandom_range(0, 3));
        prerd = 5'($urandom_range(0, 3));
        precmp = 2'($urandom_range(0, 3));
        preAluOutput = $urandom; prePC4 = $urandom;
    endtask

    task automatic do_reset();
        Reset = 0;
        #3;
        Reset = 1;
        m_rd[0] = 0; m_rd[1] = 0;
        m_vld = 0; m_wait = 0; m_dc = 0; m_fwd = 0; m_stl = 0;
    endtask

    vec_t vecs [10];
    vec_t t;

    initial begin
        for (int i = 0; i < 10; i++) vecs[i] = base();
        vecs[0].r0 = 3; vecs[0].pm = 1; vecs[0].prd = 3; vecs[0].palu = 32'h11;
        vecs[0].qm = 1; vecs[0].qrd = 3; vecs[0].qalu = 32'h22; vecs[0].e0 = 32'h11;
        vecs[1] = vecs[0]; vecs[1].pm = 0; vecs[1].e0 = 32'h22;
        vecs[2].r1 = 0; vecs[2].pm = 1; vecs[2].prd = 0; vecs[2].palu = 32'hFFFF;
        vecs[3].r1 = 31; vecs[3].pm = 1; vecs[3].pdst = 2; vecs[3].prd = 31;
        vecs[3].ppc = 32'h104; vecs[3].e1 = 32'h104;
        vecs[4].r1 = 31; vecs[4].pm = 1; vecs[4].pdst = 3; vecs[4].prd = 31;
        vecs[4].pcmp = 2'b01; vecs[4].e1 = 32'h1;
        vecs[5].r0 = 5; vecs[5].r1 = 5; vecs[5].qm = 1; vecs[5].qdst = 1;
        vecs[5].qrd = 5; vecs[5].qdat = 32'hABCD;
        vecs[5].e0 = 32'hABCD; vecs[5].e1 = 32'hABCD;
        vecs[6].v = 0; vecs[6].r0 = 3; vecs[6].pm = 1; vecs[6].prd = 3;
        vecs[6].palu = 32'h11; vecs[6].e0 = 32'h11; vecs[6].ev = 0;
        vecs[7].r0 = 3; vecs[7].pm = 1; vecs[7].pw = 0; vecs[7].prd = 3;
        vecs[8].r0 = 4; vecs[8].qm = 1; vecs[8].qrd = 4; vecs[8].qdst = 3;
        vecs[8].qcmp = 2'b10; vecs[8].e0 = 32'h0;
        vecs[9].r0 = 4; vecs[9].r1 = 6; vecs[9].pm = 1; vecs[9].prd = 4;
        vecs[9].palu = 32'h44; vecs[9].qm = 1; vecs[9].qrd = 6;
        vecs[9].qdst = 2; vecs[9].qpc = 32'h200;
        vecs[9].e0 = 32'h44; vecs[9].e1 = 32'h200;

        Reset = 0;
        drive(base());
        #12;
        chk("reset_rd0", RD[31:0], 32'h0);
        chk("reset_vld", {31'b0, out_valid}, 32'h0);
        chk("reset_stall", {31'b0, Stall}, 32'h0);
        Reset = 1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("vec%0d_rd0", i), RD[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i), RD[63:32], vecs[i].e1);
            chk($sformatf("vec%0d_vld", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("vec%0d_stall", i), {31'b0, Stall}, 32'h0);
        end

        // load-use on port 0: one stall, then WB-sourced load data
        t = base(); t.r0 = 5; t.pm = 1; t.pdst = 1; t.prd = 5; t.palu = 32'h1000;
        drive(t); step();
        chk("lu_stall", {31'b0, Stall}, 32'h1);
        chk("lu_vld", {31'b0, out_valid}, 32'h0);
        chk("lu_hold", RD[31:0], 32'h44);
        t.pm = 0; t.qm = 1; t.qdst = 1; t.qrd = 5; t.qdat = 32'hABCD;
        drive(t); step();
        chk("lu_rd0", RD[31:0], 32'hABCD);
        chk("lu_vld2", {31'b0, out_valid}, 32'h1);
        chk("lu_stall2", {31'b0, Stall}, 32'h0);
        step();
        chk("lu_stall3", {31'b0, Stall}, 32'h0);

        // both ports hit the same load: still a single stall cycle
        t = base(); t.r0 = 6; t.r1 = 6; t.pm = 1; t.pdst = 1; t.prd = 6;
        drive(t); step();
        chk("mp_stall", {31'b0, Stall}, 32'h1);
        t.pm = 0; t.qm = 1; t.qdst = 1; t.qrd = 6; t.qdat = 32'h6060;
        drive(t); step();
        chk("mp_stall2", {31'b0, Stall}, 32'h0);
        chk("mp_rd0", RD[31:0], 32'h6060);
        chk("mp_rd1", RD[63:32], 32'h6060);

        // asynchronous reset while waiting
        t = base(); t.r0 = 7; t.pm = 1; t.pdst = 1; t.prd = 7;
        drive(t); step();
        chk("rw_stall", {31'b0, Stall}, 32'h1);
        #2 Reset = 0;
        #1;
        chk("rw_stall0", {31'b0, Stall}, 32'h0);
        chk("rw_vld0", {31'b0, out_valid}, 32'h0);
        chk("rw_rd1", RD[63:32], 32'h0);
        #1 Reset = 1;
        t = base(); drive(t); step();
        chk("rw_rd0_after", RD[31:0], t.d0);
        chk("rw_rd1_after", RD[63:32], t.d1);
        chk("rw_vld_after", {31'b0, out_valid}, 32'h1);

`ifdef FWD_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(vecs[0]); step();
        end
        t = base(); t.r0 = 5; t.pm = 1; t.pdst = 1; t.prd = 5;
        drive(t); step();
        t.pm = 0; t.qm = 1; t.qdst = 1; t.qrd = 5; t.qdat = 32'hABCD;
        drive(t); step();
        chk("stats_fwd", fwd_cnt, 32'd4);
        chk("stats_stall", stall_cnt, 32'd1);
`endif

        // randomized traffic honouring the stall protocol
        @(posedge CLK); #1;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_wait) begin
                ppreMwk = preMwk; ppreRegWr = preRegWr;
                ppreRegDst = preRegDst; pprerd = prerd; pprecmp = precmp;
                ppreAluOutput = preAluOutput; pprePC4 = prePC4;
                ppreDataOut = $urandom;
                rand_pre();
                preMwk = 0;
            end else begin
                id_valid = ($urandom_range(0, 4) != 0);
                for (int p = 0; p < NP; p++) begin
                    rs[p*RB +: RB] = 5'($urandom_range(0, 3));
                    ReadData[p*XLEN +: XLEN] = $urandom;
                end
                rand_pre();
                ppreMwk = ($urandom_range(0, 3) != 0);
                ppreRegWr = ($urandom_range(0, 3) != 0);
                ppreRegDst = 2'($urandom_range(0, 3));
                pprerd = 5'($urandom_range(0, 3));
                pprecmp = 2'($urandom_range(0, 3));
                ppreAluOutput = $urandom; ppreDataOut = $urandom;
                pprePC4 = $urandom;
            end
            model_edge();
            step();
            if (!m_dc) begin
                chk($sformatf("rnd%0d_rd0", n), RD[31:0], m_rd[0]);
                chk($sformatf("rnd%0d_rd1", n), RD[63:32], m_rd[1]);
            end
            chk($sformatf("rnd%0d_vld", n), {31'b0, out_valid}, {31'b0, m_vld});
            chk($sformatf("rnd%0d_stall", n), {31'b0, Stall}, {31'b0, m_wait});
        end
`ifdef FWD_STATS_EN
        chk("rnd_fwd_cnt", fwd_cnt, m_fwd);
        chk("rnd_stall_cnt", stall_cnt, m_stl);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
